tcdm_filter_err_log: RTL and testbench

Error capture unit that sits directly downstream of the TCDM address filter. It logs every request the filter rejects: the faulting address and direction go into a small FIFO, and a saturating violation counter is incremented. An interrupt is raised while the FIFO holds entries. Software drains the log and clears status through a 4-word TCDM-style configuration slave.

---
 rtl/tcdm_filter_pkg.sv | 19 +
 rtl/tcdm_filter_err_log_if.sv | 20 ++
 rtl/errlog_fifo.sv | 52 +++++
 rtl/tcdm_filter_err_log.sv | 108 ++++++++++
 tb/tb_tcdm_filter_err_log.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/tcdm_filter_pkg.sv
// rtl/tcdm_filter_pkg.sv - shared types and constants for the TCDM address filter and its error log
package tcdm_filter_pkg;

    // Byte offsets of the error-log configuration registers
    localparam logic [3:0] ERRLOG_CTRL      = 4'h0;
    localparam logic [3:0] ERRLOG_HEAD_ADDR = 4'h4;
    localparam logic [3:0] ERRLOG_HEAD_INFO = 4'h8;
    localparam logic [3:0] ERRLOG_COUNT     = 4'hC;

    // Read data the filter returns for rejected reads
    localparam logic [31:0] ERR_RDATA = 32'hBADE5505;

    // One logged rejection as seen by software (address zero-extended to 32 bits)
    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
    } errlog_entry_t;

endpackage

// File: rtl/tcdm_filter_err_log_if.sv
// rtl/tcdm_filter_err_log_if.sv - TCDM-style configuration bus of the error log
interface tcdm_filter_err_log_if;
    logic        cfg_req_i;
    logic [3:0]  cfg_add_i;
    logic        cfg_wen_i;
    logic [31:0] cfg_wdata_i;
    logic        cfg_gnt_o;
    logic [31:0] cfg_r_rdata_o;
    logic        cfg_r_valid_o;

    modport master (
        output cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i,
        input  cfg_gnt_o, cfg_r_rdata_o, cfg_r_valid_o
    );

    modport slave (
        input  cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i,
        output cfg_gnt_o, cfg_r_rdata_o, cfg_r_valid_o
    );
endinterface

// File: rtl/errlog_fifo.sv
// rtl/errlog_fifo.sv - circular-buffer FIFO holding logged rejections
module errlog_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             pop_eff;
    logic             push_eff;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rptr];

    // A pop on empty is dropped; a pop on full frees the slot a same-cycle push needs
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);

    // Storage array; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_eff) wptr <= wptr + 1'b1;
            if (pop_eff)  rptr <= rptr + 1'b1;
            if (push_eff && !pop_eff)      level <= level + 1'b1;
            else if (pop_eff && !push_eff) level <= level - 1'b1;
        end
    end
endmodule

// File: rtl/tcdm_filter_err_log.sv
// rtl/tcdm_filter_err_log.sv - logs filter rejections, counts them, raises irq while the log is non-empty
module tcdm_filter_err_log
    import tcdm_filter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  error_i,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    tcdm_filter_err_log_if.slave  cfg,
    output logic                  irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH:0]  fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LW-1:0]        fifo_level;
    logic                 pop_req;
    logic                 ctrl_wr;
    logic                 cnt_clr;
    logic                 irq_en;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] cnt;
    logic [31:0]          rdata_next;
    logic [1:0]           sel;
    errlog_entry_t        head;
    logic                 unused_cfg;

    assign sel       = cfg.cfg_add_i[3:2];
    assign ctrl_wr   = cfg.cfg_req_i & ~cfg.cfg_wen_i & (sel == ERRLOG_CTRL[3:2]);
    assign pop_req   = cfg.cfg_req_i & ~cfg.cfg_wen_i & (sel == ERRLOG_HEAD_INFO[3:2]);
    assign cnt_clr   = cfg.cfg_req_i & ~cfg.cfg_wen_i & (sel == ERRLOG_COUNT[3:2]);
    assign cfg.cfg_gnt_o = cfg.cfg_req_i;
    assign irq_o     = irq_en & ~fifo_empty;
    assign unused_cfg = ^{cfg.cfg_add_i[1:0], cfg.cfg_wdata_i[31:1]};

    // Head entry is presented as zero when the log is empty
    assign head.addr = fifo_empty ? 32'h0 : 32'(fifo_rdata[ADDR_WIDTH:1]);
    assign head.wen  = ~fifo_empty & fifo_rdata[0];

    errlog_fifo #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (error_i),
        .pop   (pop_req),
        .wdata ({add_i, wen_i}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Read mux samples state before this cycle's pop, push or clear; writes answer zero
    always_comb begin
        rdata_next = 32'h0;
        if (cfg.cfg_wen_i) begin
            case (sel)
                ERRLOG_CTRL[3:2]:      rdata_next = {16'h0, 8'(fifo_level), 5'h0,
                                                     fifo_empty, overflow, irq_en};
                ERRLOG_HEAD_ADDR[3:2]: rdata_next = head.addr;
                ERRLOG_HEAD_INFO[3:2]: rdata_next = {~fifo_empty, 30'h0, head.wen};
                default:               rdata_next = 32'(cnt);
            endcase
        end
    end

    // Configuration response: one cycle after every granted access
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg.cfg_r_valid_o <= 1'b0;
            cfg.cfg_r_rdata_o <= 32'h0;
        end else begin
            cfg.cfg_r_valid_o <= cfg.cfg_req_i;
            if (cfg.cfg_req_i) cfg.cfg_r_rdata_o <= rdata_next;
        end
    end

    // Status: a dropped capture sets overflow even when COUNT is cleared in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= cfg.cfg_wdata_i[0];
            if (error_i && fifo_full && !(pop_req && !fifo_empty)) overflow <= 1'b1;
            else if (cnt_clr)                                     overflow <= 1'b0;
        end
    end

    // Saturating violation counter; a clear overrides a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (error_i && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tcdm_filter_err_log.sv
// tb/tb_tcdm_filter_err_log.sv - scoreboard bench for tcdm_filter_err_log
module tb_tcdm_filter_err_log;
    logic        clk = 1'b0;
    logic        rst;
    logic        error_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    tcdm_filter_err_log_if cfg_bus ();

    tcdm_filter_err_log #(
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .error_i (error_i),
        .add_i   (add_i),
        .wen_i   (wen_i),
        .cfg     (cfg_bus.slave),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response is compared with the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (cfg_bus.cfg_r_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rvalid: got rdata 0x%08h with no access pending",
                             cfg_bus.cfg_r_rdata_o);
                end else begin
                    check(name_q.pop_front(), cfg_bus.cfg_r_rdata_o, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one access (called at posedge+1) and queue its expected response
    task automatic cfg_acc(input logic wen, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp, input string name);
        cfg_bus.cfg_req_i   = 1'b1;
        cfg_bus.cfg_wen_i   = wen;
        cfg_bus.cfg_add_i   = addr;
        cfg_bus.cfg_wdata_i = wdata;
        exp_q.push_back(exp);
        name_q.push_back(name);
        check({name, "_gnt"}, {31'h0, cfg_bus.cfg_gnt_o}, 32'h1);
        @(posedge clk);
        #1;
        cfg_bus.cfg_req_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
        cfg_acc(1'b1, addr, 32'h0, exp, name);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wdata, input string name);
        cfg_acc(1'b0, addr, wdata, 32'h0, name);
    endtask

    task automatic err(input logic [31:0] addr, input logic wen);
        error_i = 1'b1;
        add_i   = addr;
        wen_i   = wen;
        @(posedge clk);
        #1;
        error_i = 1'b0;
    endtask

    // Config write and rejection strobe presented in the same cycle
    task automatic wr_with_err(input logic [3:0] caddr, input logic [31:0] eaddr,
                               input logic ewen, input string name);
        error_i = 1'b1;
        add_i   = eaddr;
        wen_i   = ewen;
        cfg_acc(1'b0, caddr, 32'h0, 32'h0, name);
        error_i = 1'b0;
    endtask

    logic [31:0] drain_addr [4];
    logic        drain_wen  [4];

    initial begin
        rst = 1'b1;
        error_i = 1'b0;
        add_i = 32'h0;
        wen_i = 1'b0;
        cfg_bus.cfg_req_i = 1'b0;
        cfg_bus.cfg_wen_i = 1'b0;
        cfg_bus.cfg_add_i = 4'h0;
        cfg_bus.cfg_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rvalid", {31'h0, cfg_bus.cfg_r_valid_o}, 32'h0);
        check("reset_rdata", cfg_bus.cfg_r_rdata_o, 32'h0);
        check("reset_irq", {31'h0, irq_o}, 32'h0);

        rd(4'h0, 32'h0000_0004, "ctrl_after_reset");

        // Single capture and drain
        wr(4'h0, 32'h1, "wr_irq_en");
        err(32'h1C00_8000, 1'b0);
        check("irq_after_err", {31'h0, irq_o}, 32'h1);
        rd(4'h4, 32'h1C00_8000, "head_addr_single");
        rd(4'h8, 32'h8000_0000, "head_info_single");
        wr(4'h8, 32'h0, "pop_single");
        check("irq_after_pop", {31'h0, irq_o}, 32'h0);
        rd(4'h0, 32'h0000_0005, "ctrl_empty_irqen");
        rd(4'h8, 32'h0000_0000, "head_info_empty");
        rd(4'h4, 32'h0000_0000, "head_addr_empty");
        wr(4'h8, 32'h0, "pop_empty_noop");
        rd(4'h0, 32'h0000_0005, "ctrl_after_empty_pop");

        // Six back-to-back rejections into a 4-deep log
        wr(4'hC, 32'h0, "clr_count_1");
        for (int i = 0; i < 6; i++) begin
            err(32'h100 + 32'(4 * i), i[0]);
        end
        rd(4'h0, 32'h0000_0403, "ctrl_full_overflow");
        rd(4'hC, 32'h0000_0006, "count_six");
        check("irq_full", {31'h0, irq_o}, 32'h1);
        rd(4'h4, 32'h0000_0100, "head_addr_first");
        rd(4'h8, 32'h8000_0000, "head_info_first");

        // Full log: pop and rejection in the same cycle
        wr(4'hC, 32'h0, "clr_count_2");
        rd(4'h0, 32'h0000_0401, "ctrl_overflow_cleared");
        wr_with_err(4'h8, 32'h200, 1'b1, "pop_with_push_full");
        rd(4'h0, 32'h0000_0401, "ctrl_after_pop_push");
        drain_addr = '{32'h104, 32'h108, 32'h10C, 32'h200};
        drain_wen  = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            rd(4'h4, drain_addr[i], $sformatf("drain_addr_%0d", i));
            rd(4'h8, {1'b1, 30'h0, drain_wen[i]}, $sformatf("drain_info_%0d", i));
            wr(4'h8, 32'h0, $sformatf("drain_pop_%0d", i));
        end
        rd(4'h0, 32'h0000_0005, "ctrl_drained");
        rd(4'hC, 32'h0000_0001, "count_after_clr_then_err");

        // Counter saturation with a 4-bit counter, then clear racing a rejection
        wr(4'hC, 32'h0, "clr_count_3");
        for (int i = 0; i < 17; i++) begin
            err(32'h300 + 32'(4 * i), 1'b0);
        end
        rd(4'hC, 32'h0000_000F, "count_saturated");
        wr(4'hC, 32'h0, "clr_count_4");
        rd(4'h0, 32'h0000_0401, "ctrl_overflow_clr");
        wr_with_err(4'hC, 32'h400, 1'b0, "clr_with_err");
        rd(4'hC, 32'h0000_0000, "count_clear_wins");
        rd(4'h0, 32'h0000_0403, "ctrl_overflow_kept");

        // Reset the cycle after a read request
        cfg_acc(1'b1, 4'h0, 32'h0, 32'h0000_0403, "ctrl_before_reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rvalid_after_reset", {31'h0, cfg_bus.cfg_r_valid_o}, 32'h0);
        check("irq_after_reset", {31'h0, irq_o}, 32'h0);
        rd(4'h0, 32'h0000_0004, "ctrl_post_reset");
        rd(4'hC, 32'h0000_0000, "count_post_reset");
        rd(4'h8, 32'h0000_0000, "info_post_reset");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_responses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
